// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: bypass select codes and scoreboard states.
// No logic, so no latency.
// No flow control.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;  // register file
  localparam fwd_sel_t FWD_EXMEM = 2'b10;  // producer now in EX/MEM
  localparam fwd_sel_t FWD_MEMWB = 2'b01;  // producer now in MEM/WB
  localparam fwd_sel_t FWD_MDU   = 2'b11;  // held MDU result

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_mdu_scoreboard.sv
// Tracks the single in-flight MDU op: countdown, destination, busy flag and write-back pulse.
// Issue is seen on the next edge; mdu_wb is high the cycle the countdown reads 1.
// No backpressure; the parent never issues while busy.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [REG_AW-1:0] mdu_rd_o,
  output logic              busy_o,
  output logic              wb_o
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  sb_state_e         state_q;
  logic              wb_q;

  // Load the countdown on issue, otherwise run it down to zero.
  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    if (issue_i) begin
      count_d = CNT_W'(MDU_LAT);
      rd_d    = issue_rd_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Busy and write-back flags are registered from the next count so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rd_q    <= '0;
      state_q <= SB_IDLE;
      wb_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      state_q <= (count_d != '0) ? SB_BUSY : SB_IDLE;
      wb_q    <= (count_d == CNT_W'(1));
    end
  end

  assign count_o  = count_q;
  assign mdu_rd_o = rd_q;
  assign busy_o   = (state_q == SB_BUSY);
  assign wb_o     = wb_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection in ID and registered per-source bypass selects for EX; optional FWD_MDU_BYPASS_EN.
// stall is combinational; fwd_sel has one cycle of latency.
// stall freezes IF/ID and bubbles ID/EX (fwd_sel cleared); flush kills ID without cancelling an issued MDU op.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_mdu,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      mdu_busy,
  output logic                      mdu_wb,
  output logic [REG_AW-1:0]         mdu_wb_rd
);

  logic [CNT_W-1:0]     count;
  logic [REG_AW-1:0]    mdu_rd;
  logic [NUM_SRC-1:0]   hit_ex, hit_mem, hit_mdu;
  logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;
  logic                 live, advance, issue;
  logic                 load_use, mdu_raw, mdu_struct, mdu_waw;

  assign live    = id_valid & ~flush;
  assign advance = live & ~stall;
  assign issue   = advance & id_mdu;

  mdu_scoreboard #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (issue),
    .issue_rd_i(id_rd),
    .count_o   (count),
    .mdu_rd_o  (mdu_rd),
    .busy_o    (mdu_busy),
    .wb_o      (mdu_wb)
  );

  assign mdu_wb_rd = mdu_rd;

`ifdef FWD_MDU_BYPASS_EN
  logic mdu_last;
  assign mdu_last = (count == CNT_W'(1));
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    fwd_sel_t          sel_nxt;

    assign rs         = id_rs[i*REG_AW +: REG_AW];
    // x0 is never a real dependency, so it never matches.
    assign hit_ex[i]  = id_rs_used[i] && (rs != '0) && (rs == ex_rd);
    assign hit_mem[i] = id_rs_used[i] && (rs != '0) && (rs == mem_rd);
    assign hit_mdu[i] = id_rs_used[i] && (rs != '0) && (rs == mdu_rd);

    // Bypass priority: MDU result, then youngest ALU producer, then older one.
    always_comb begin
      sel_nxt = FWD_RF;
`ifdef FWD_MDU_BYPASS_EN
      if (mdu_last && hit_mdu[i])          sel_nxt = FWD_MDU;
      else if (ex_regwrite && hit_ex[i])   sel_nxt = FWD_EXMEM;
      else if (mem_regwrite && hit_mem[i]) sel_nxt = FWD_MEMWB;
`else
      if (ex_regwrite && hit_ex[i])        sel_nxt = FWD_EXMEM;
      else if (mem_regwrite && hit_mem[i]) sel_nxt = FWD_MEMWB;
`endif
    end

    assign fwd_sel_d[i*2 +: 2] = advance ? sel_nxt : FWD_RF;
  end

  assign load_use   = ex_is_load & ex_regwrite & (|hit_ex);
`ifdef FWD_MDU_BYPASS_EN
  // The held result is bypassable in the write-back cycle, so release one cycle early.
  assign mdu_raw    = mdu_busy & (|hit_mdu) & (count > CNT_W'(1));
`else
  // Without the bypass the consumer waits until the result is in the register file.
  assign mdu_raw    = mdu_busy & (|hit_mdu) & (count != '0);
`endif
  assign mdu_struct = id_mdu & mdu_busy;
  assign mdu_waw    = id_regwrite & mdu_busy & (id_rd == mdu_rd) & (id_rd != '0);

  assign stall = live & (load_use | mdu_raw | mdu_struct | mdu_waw);

  // Selects travel with the instruction into EX; a bubble carries the register-file select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_sel_q <= '0;
    else        fwd_sel_q <= fwd_sel_d;
  end

  assign fwd_sel = fwd_sel_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomised and directed stimulus against a cycle-level reference model; scoreboard checks outputs.
// Expectations are queued when stimulus is applied and compared mid-cycle by a monitor.
// Build with or without FWD_MDU_BYPASS_EN; the model follows the same macro.
module tb_hazard_fwd_ctrl;
  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int LAT = 4;
`ifdef FWD_MDU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b1;
  logic           rst_n;
  logic           id_valid;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0]  id_rs_used;
  logic [AW-1:0]  id_rd;
  logic           id_regwrite, id_mdu;
  logic [AW-1:0]  ex_rd;
  logic           ex_regwrite, ex_is_load;
  logic [AW-1:0]  mem_rd;
  logic           mem_regwrite, flush;
  logic           stall;
  logic [NS*2-1:0] fwd_sel;
  logic           mdu_busy, mdu_wb;
  logic [AW-1:0]  mdu_wb_rd;

  hazard_fwd_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_mdu(id_mdu), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_wb_rd(mdu_wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        stall;
    bit [3:0]  fwd;
    bit        busy;
    bit        wb;
    bit [4:0]  wb_rd;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  bit   done = 0;

  // Reference model state: cycles until the MDU result lands, its destination,
  // and the selects the instruction now in EX was given.
  int       left = 0;
  bit [4:0] dest = 0;
  bit [3:0] fwd_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input int i, input bit [4:0] r);
    bit [4:0] s;
    s = id_rs[i*AW +: AW];
    return id_rs_used[i] && r != 0 && s == r;
  endfunction

  function automatic bit reads_any(input bit [4:0] r);
    bit h = 0;
    for (int i = 0; i < NS; i++) h |= reads(i, r);
    return h;
  endfunction

  function automatic bit model_stall();
    bit lu, raw, st, waw;
    if (!id_valid || flush) return 0;
    lu  = ex_is_load && ex_regwrite && reads_any(ex_rd);
    raw = (left > 0) && reads_any(dest) && (BYP ? (left > 1) : 1'b1);
    st  = id_mdu && left > 0;
    waw = id_regwrite && left > 0 && id_rd == dest && id_rd != 0;
    return lu || raw || st || waw;
  endfunction

  function automatic bit [3:0] model_next();
    bit [3:0] v = 0;
    for (int i = 0; i < NS; i++) begin
      bit [1:0] s;
      if (BYP && left == 1 && reads(i, dest))     s = 2'b11;
      else if (ex_regwrite && reads(i, ex_rd))    s = 2'b10;
      else if (mem_regwrite && reads(i, mem_rd))  s = 2'b01;
      else                                        s = 2'b00;
      v[i*2 +: 2] = s;
    end
    return v;
  endfunction

  // Queue the expectation for the current inputs, then advance the model across the edge.
  task automatic step();
    exp_t e;
    bit st, adv;
    bit [3:0] nxt;
    if (!rst_n) begin left = 0; dest = 0; fwd_exp = 0; end
    st  = model_stall();
    nxt = model_next();
    adv = id_valid && !flush && !st;
    e.stall = st; e.fwd = fwd_exp; e.busy = (left > 0); e.wb = (left == 1); e.wb_rd = dest;
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      fwd_exp = adv ? nxt : 4'd0;
      if (adv && id_mdu) begin left = LAT; dest = id_rd; end
      else if (left > 0) left--;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rd = 0; id_regwrite = 0; id_mdu = 0;
    ex_rd = 0; ex_regwrite = 0; ex_is_load = 0; mem_rd = 0; mem_regwrite = 0; flush = 0;
  endtask

  task automatic set_id(input bit [4:0] rs1, input bit [4:0] rs2, input bit [1:0] used,
                        input bit [4:0] rd, input bit wr, input bit mdu);
    id_valid = 1; id_rs = {rs2, rs1}; id_rs_used = used; id_rd = rd;
    id_regwrite = wr; id_mdu = mdu;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stall", stall, e.stall);
        check("fwd_sel", fwd_sel, e.fwd);
        check("mdu_busy", mdu_busy, e.busy);
        check("mdu_wb", mdu_wb, e.wb);
        if (e.wb) check("mdu_wb_rd", mdu_wb_rd, e.wb_rd);
      end
    end
  end

  initial begin
    int n;
    idle();
    rst_n = 0;
    #1;
    step(); step();
    rst_n = 1;
    step();

    // ALU producer in EX, dependent consumer in ID.
    ex_rd = 5; ex_regwrite = 1; set_id(5, 0, 2'b01, 6, 1, 0); step();
    idle(); step();

    // Same register in EX and MEM: EX wins for source 1.
    ex_rd = 7; ex_regwrite = 1; mem_rd = 7; mem_regwrite = 1;
    set_id(0, 7, 2'b10, 8, 1, 0); step();
    idle(); step();

    // Load-use: one stall, then MEM/WB forwarding.
    ex_rd = 9; ex_regwrite = 1; ex_is_load = 1; set_id(9, 1, 2'b11, 10, 1, 0); step();
    ex_rd = 0; ex_regwrite = 0; ex_is_load = 0; mem_rd = 9; mem_regwrite = 1; step();
    idle(); step();
    // Load into x0 is never a hazard.
    ex_rd = 0; ex_regwrite = 1; ex_is_load = 1; set_id(0, 0, 2'b11, 10, 1, 0); step();
    idle(); step();

    // MDU RAW: measure the stall length the consumer sees.
    set_id(0, 0, 2'b00, 3, 1, 1); step();
    set_id(3, 0, 2'b01, 4, 1, 0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      bit s;
      #1 s = stall;
      step();
      if (!s) break;
      n++;
    end
    check("mdu_raw_len", n, BYP ? LAT - 1 : LAT);
    idle(); step(); step();

    // Structural and WAW stalls, then a flush during the stall.
    set_id(0, 0, 2'b00, 3, 1, 1); step();
    set_id(0, 0, 2'b00, 11, 1, 1); step();
    set_id(1, 2, 2'b11, 3, 1, 0); step();
    flush = 1; step();
    flush = 0; idle();
    for (int k = 0; k < LAT + 2; k++) step();

    // Reset while the countdown reads 2 aborts the op.
    set_id(0, 0, 2'b00, 12, 1, 1); step();
    idle();
    for (int k = 0; k < LAT - 2; k++) step();
    rst_n = 0; step();
    rst_n = 1;
    for (int k = 0; k < LAT + 2; k++) step();

    // Random traffic on a small register range to make collisions common.
    for (int k = 0; k < 3000; k++) begin
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used   = 2'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 7));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_mdu       = ($urandom_range(0, 5) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_is_load   = ($urandom_range(0, 3) == 0);
      mem_rd       = 5'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 11) == 0);
      rst_n        = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1; idle(); step();

    repeat (3) @(negedge clk);
    if (q.size() != 0) check("queue_drained", q.size(), 0);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It resolves operand hazards in ID and registers per-source bypass selects into the ID/EX boundary, where the EX operand muxes consume them. It also raises the ID stall for load-use hazards. It owns a scoreboard for the single multi-cycle MDU (mul/div) in flight: RAW, WAW and structural stalls, plus MDU write-back timing.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction.
- REG_AW, 5: register index width.
- MDU_LAT, 4: MDU latency in cycles, ≥2.
- CNT_W, $clog2(MDU_LAT+1): width of the MDU countdown counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source indices; source i occupies slice i.
- id_rs_used  in  NUM_SRC  source i is actually read.
- id_rd  in  REG_AW  destination index.
- id_regwrite  in  1  instruction writes id_rd.
- id_mdu  in  1  instruction is an MDU op.
- ex_rd, ex_regwrite, ex_is_load  in  REG_AW/1/1  producer currently in ID/EX.
- mem_rd, mem_regwrite  in  REG_AW/1  producer currently in EX/MEM.
- flush  in  1  taken branch/jump; kills the ID instruction.
- stall  out  1  combinational; freeze PC and IF/ID, insert a bubble into ID/EX.
- fwd_sel  out  NUM_SRC*2  registered bypass select per source, valid in EX.
- mdu_busy  out  1  MDU op in flight.
- mdu_wb  out  1  MDU result writes the register file this cycle.
- mdu_wb_rd  out  REG_AW  destination for mdu_wb.

## Operation
- A source i "matches" register r when: id_rs_used[i], r == id_rs[i], and r != 0.
- Select codes: 00 register file, 10 EX/MEM, 01 MEM/WB, 11 MDU result.
- Next select per source, highest priority first:
  - 11 if FWD_MDU_BYPASS_EN, count == 1, and mdu_rd matches.
  - 10 if ex_regwrite and ex_rd matches; the producer reaches EX/MEM as the consumer enters EX.
  - 01 if mem_regwrite and mem_rd matches.
  - 00 otherwise.
- Stall conditions, each ANDed with id_valid & !flush:
  - load_use: ex_is_load & ex_regwrite & ex_rd matches any source.
  - mdu_raw: mdu_busy & mdu_rd matches any source & (count > 1 with macro, count ≥ 1 without).
  - mdu_struct: id_mdu & mdu_busy.
  - mdu_waw: id_regwrite & mdu_busy & id_rd == mdu_rd & id_rd != 0.
- The register file is write-before-read. The WB-stage producer and the mdu_wb write need no forwarding.
- Scoreboard states:
  - IDLE (count = 0).
  - BUSY (count ≥ 1).
  - Issue = id_valid & id_mdu & !stall & !flush: load count = MDU_LAT and mdu_rd = id_rd.
  - Decrement count each cycle while nonzero.
  - mdu_wb = (count == 1); mdu_wb_rd = mdu_rd.
  - Issue is impossible while busy (mdu_struct), so there is no load/decrement conflict.
- flush does not cancel an MDU op that has already issued.

## Timing
- Reset: fwd_sel = 0, count = 0, mdu_rd = 0, hence mdu_busy = 0 and mdu_wb = 0.
- Reset asserted mid-operation aborts the in-flight MDU op; no mdu_wb is produced.
- fwd_sel: one-cycle latency. Loaded each edge with the next select when id_valid & !stall & !flush; otherwise loaded with 0 (bubble).
- stall: zero latency, combinational from inputs and scoreboard state.
- Load-use costs exactly 1 stall cycle. The consumer then enters EX with select 01.
- MDU RAW stall length after issue:
  - MDU_LAT-1 cycles with macro; consumer enters EX with select 11.
  - MDU_LAT cycles without; consumer enters EX with select 00.
- mdu_busy deasserts the cycle after mdu_wb.

## Configuration
- FWD_MDU_BYPASS_EN defined:
  - Select 11 is generated.
  - RAW stall releases at count == 1.
  - The datapath holds the MDU result until the next issue.
- Not defined:
  - Select 11 never appears.
  - RAW stall holds until count == 0, one extra cycle.
  - The MDU result is read from the register file.

## Structure
- hazard_pkg holds:
  - Select constants FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_MDU.
  - The fwd_sel_t 2-bit typedef.
- Sub-module mdu_scoreboard holds count, mdu_rd, mdu_busy and mdu_wb. The top level contains the compare and priority logic, generated per source.

## Test plan
- Back-to-back ALU ops: add x5 in ID/EX, then sub using x5 as rs1 → no stall; fwd_sel[1:0] = 10 next cycle.
- Two-deep dependency: mem_rd = 7 and ex_rd = 7, consumer rs2 = x7 → fwd_sel[3:2] = 10 (EX wins).
- Load-use: lw x9 in ID/EX, consumer reads x9 → stall = 1 for one cycle, then fwd_sel = 01. Repeating with rd = x0 gives no stall.
- MDU RAW with MDU_LAT = 4: mul x3 issues, consumer reads x3.
  - With macro: 3 stall cycles, then select 11.
  - Without macro: 4 stall cycles, then select 00.
  - In both cases mdu_wb pulses with mdu_wb_rd = 3.
- Structural/WAW: second MDU op, or addi x3 while mul x3 is busy → stall until mdu_busy clears. flush during the stall → stall = 0, fwd_sel = 0.
- Reset asserted with count = 2 → outputs zero immediately; no mdu_wb after release.
